uart_transmit_fifo: RTL and testbench

- Serial UART transmitter behind the CPU's memory-mapped UART write port (store to 0x80000008, write-enable WEUART).
- Accepts bytes over a ready/valid handshake and buffers them in a small FIFO.
- Emits 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) on SOut.
- DataInReady feeds the CPU's DataInReady status word at 0x80000000.

---
 rtl/uart_transmit_fifo_pkg.sv | 25 ++
 rtl/uart_tx_fifo.sv | 62 ++++++
 rtl/uart_transmit_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_transmit_fifo.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_transmit_fifo_pkg.sv
// uart_transmit_fifo_pkg
//   Shared definitions for the UART transmit path:
//   - tx_state_e : 2-bit transmitter FSM encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   - UART MMIO address map used by the CPU control logic and the UART wrapper
//   - cycles_per_bit() : clock cycles per serial bit, truncating division
package uart_transmit_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // UART memory-mapped registers as seen by the CPU.
    localparam logic [31:0] UART_ADDR_STATUS = 32'h8000_0000;  // DataInReady / DataOutValid
    localparam logic [31:0] UART_ADDR_RXDATA = 32'h8000_0004;
    localparam logic [31:0] UART_ADDR_TXDATA = 32'h8000_0008;  // store here with WEUART
    localparam logic [31:0] UART_ADDR_CTRL   = 32'h8000_000C;

    function automatic int cycles_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Synchronous FIFO buffering bytes waiting for the serial transmitter.
//   Pointers carry one extra wrap bit so full and empty can be told apart.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous, active-high; empties the FIFO
//   push   in   write din (ignored while full)
//   din    in   data to write
//   pop    in   advance the read pointer (ignored while empty)
//   dout   out  head of the FIFO (valid while !empty)
//   full   out  no free entries
//   empty  out  no stored entries
module uart_tx_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [Width-1:0] din,
    input  logic             pop,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AddrW = $clog2(Depth);

    logic [AddrW:0]   wptr;
    logic [AddrW:0]   rptr;
    logic [Width-1:0] mem [Depth];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    // Same slot but opposite lap: the writer is exactly one lap ahead.
    assign full    = (wptr[AddrW] != rptr[AddrW]) &&
                     (wptr[AddrW-1:0] == rptr[AddrW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[AddrW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; resetting the
    // pointers already makes its contents unreachable, and leaving it
    // unreset lets it map onto plain RAM.
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr[AddrW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_transmit_fifo.sv
// uart_transmit_fifo
//   8N1 UART transmitter with a small byte FIFO in front of it. Bytes are
//   accepted over a ready/valid handshake and sent LSB first, back to back
//   when the FIFO keeps supplying them.
// Parameters:
//   ClockFreq  system clock in Hz
//   BaudRate   serial bit rate
//   FifoDepth  buffered bytes (power of two, >= 2)
// Ports:
//   Clock        in   system clock
//   Reset        in   synchronous, active-high; aborts any frame, flushes FIFO
//   DataIn       in   byte to transmit
//   DataInValid  in   DataIn holds a valid byte
//   DataInReady  out  FIFO can take a byte (!full)
//   SOut         out  registered serial line, idles high
//   Busy         out  a frame is in progress or bytes are queued
module uart_transmit_fifo
    import uart_transmit_fifo_pkg::*;
#(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200,
    parameter int FifoDepth = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic       SOut,
    output logic       Busy
);

    localparam int CyclesPerBit = cycles_per_bit(ClockFreq, BaudRate);
    localparam int BaudW        = (CyclesPerBit > 1) ? $clog2(CyclesPerBit) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CyclesPerBit - 1);

    tx_state_e        state, state_d;
    logic [7:0]       sh, sh_d;
    logic [2:0]       bitcnt, bitcnt_d;
    logic [BaudW-1:0] baudcnt, baudcnt_d;
    logic             sout_q, sout_d;
    logic             bit_end;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;

    uart_tx_fifo #(
        .Width (8),
        .Depth (FifoDepth)
    ) u_fifo (
        .clock (Clock),
        .reset (Reset),
        .push  (DataInValid),
        .din   (DataIn),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_end     = (baudcnt == BaudLast);
    assign DataInReady = !fifo_full;
    assign SOut        = sout_q;
    assign Busy        = (state != IDLE) || !fifo_empty;

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state;
        sh_d      = sh;
        bitcnt_d  = bitcnt;
        baudcnt_d = bit_end ? '0 : baudcnt + 1'b1;
        fifo_pop  = 1'b0;

        unique case (state)
            IDLE: begin
                baudcnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_d     = fifo_dout;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bitcnt_d = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bitcnt == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        sh_d     = {1'b0, sh[7:1]};
                        bitcnt_d = bitcnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when more data
                    // is waiting, so consecutive frames have no idle gap.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        sh_d     = fifo_dout;
                        state_d  = START;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is computed from the next state and registered,
        // so SOut changes exactly on the edge that enters each bit.
        unique case (state_d)
            START:   sout_d = 1'b0;
            DATA:    sout_d = sh_d[0];
            default: sout_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            sh      <= '0;
            bitcnt  <= '0;
            baudcnt <= '0;
            sout_q  <= 1'b1;
        end else begin
            state   <= state_d;
            sh      <= sh_d;
            bitcnt  <= bitcnt_d;
            baudcnt <= baudcnt_d;
            sout_q  <= sout_d;
        end
    end

endmodule

// File: tb/tb_uart_transmit_fifo.sv
// tb_uart_transmit_fifo
//   Directed and randomized bench for uart_transmit_fifo at 10 cycles/bit.
//   A serial receiver model decodes SOut independently of the RTL and its
//   bytes are compared against the bytes the bench handed over.
module tb_uart_transmit_fifo;

    localparam int ClockFreq = 1000;
    localparam int BaudRate  = 100;
    localparam int FifoDepth = 4;
    localparam int Cpb       = ClockFreq / BaudRate;
    localparam int FrameLen  = 10 * Cpb;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;
    logic       SOut;
    logic       Busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;

    logic [7:0] rx_q[$];
    int         start_q[$];
    logic [7:0] exp_q[$];

    logic       mon_active = 1'b0;
    int         mon_cnt    = 0;
    int         mon_idx    = 0;
    logic [7:0] mon_byte   = '0;

    uart_transmit_fifo #(
        .ClockFreq (ClockFreq),
        .BaudRate  (BaudRate),
        .FifoDepth (FifoDepth)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .DataIn      (DataIn),
        .DataInValid (DataInValid),
        .DataInReady (DataInReady),
        .SOut        (SOut),
        .Busy        (Busy)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Present a byte and hold it until the DUT takes it. Valid is left high;
    // the caller drops it or presents the next byte.
    task automatic send(input logic [7:0] b);
        DataIn      = b;
        DataInValid = 1'b1;
        for (int t = 0; t < 1000 && DataInReady !== 1'b1; t++) tick();
        check("send_ready", DataInReady, 1'b1);
        tick();
        last_acc = cyc;
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        for (int t = 0; t < budget && rx_q.size() < n; t++) tick();
        check(tag, rx_q.size(), n);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int t = 0; t < budget && Busy !== 1'b0; t++) tick();
        check(tag, Busy, 1'b0);
    endtask

    task automatic compare_rx(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size())
                check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        end
    endtask

    task automatic clear_rx();
        rx_q.delete();
        start_q.delete();
        exp_q.delete();
    endtask

    // Serial receiver model: finds a start bit, samples each bit near its
    // centre, checks the framing and collects the decoded byte.
    always @(negedge Clock) begin
        if (Reset === 1'b1) begin
            mon_active = 1'b0;
        end else if (mon_active) begin
            mon_cnt++;
            if (mon_cnt % Cpb == Cpb / 2) begin
                mon_idx = mon_cnt / Cpb;
                if (mon_idx == 0) begin
                    check("mon_start_bit", SOut, 1'b0);
                end else if (mon_idx <= 8) begin
                    mon_byte[mon_idx-1] = SOut;
                end else begin
                    check("mon_stop_bit", SOut, 1'b1);
                    rx_q.push_back(mon_byte);
                    mon_active = 1'b0;
                end
            end
        end else if (SOut === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
            start_q.push_back(cyc);
        end
    end

    initial begin
        logic [9:0] frame;
        int         a0;
        logic       any_low;

        Reset       = 1'b1;
        DataIn      = '0;
        DataInValid = 1'b0;
        repeat (3) tick();
        check("rst_sout",  SOut, 1'b1);
        check("rst_ready", DataInReady, 1'b1);
        check("rst_busy",  Busy, 1'b0);
        Reset = 1'b0;
        tick();
        check("idle_sout", SOut, 1'b1);

        // 1: single byte, exact bit timing
        clear_rx();
        send(8'hA5);
        DataInValid = 1'b0;
        check("t1_busy_queued", Busy, 1'b1);
        tick();
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < FrameLen; k++) begin
            if (k % Cpb == 0 || k % Cpb == Cpb - 1)
                check($sformatf("t1_bit%0d_c%0d", k / Cpb, k % Cpb), SOut, frame[k / Cpb]);
            if (k == FrameLen - 1) check("t1_busy_last", Busy, 1'b1);
            tick();
        end
        check("t1_busy_end", Busy, 1'b0);
        check("t1_sout_end", SOut, 1'b1);
        exp_q = '{8'hA5};
        wait_frames("t1_frames", 1, 50);
        compare_rx("t1");

        // 2: three consecutive pushes, back-to-back frames
        clear_rx();
        send(8'h01); check("t2_ready0", DataInReady, 1'b1);
        send(8'h02); check("t2_ready1", DataInReady, 1'b1);
        send(8'h03); check("t2_ready2", DataInReady, 1'b1);
        DataInValid = 1'b0;
        exp_q = '{8'h01, 8'h02, 8'h03};
        wait_frames("t2_frames", 3, 400);
        compare_rx("t2");
        if (start_q.size() >= 3) begin
            check("t2_gap01", start_q[1] - start_q[0], FrameLen);
            check("t2_gap12", start_q[2] - start_q[1], FrameLen);
        end
        wait_idle("t2_idle", 200);

        // 3: valid held high until the FIFO fills
        clear_rx();
        send(8'h10); a0 = last_acc; check("t3_ready_b0", DataInReady, 1'b1);
        send(8'h11); check("t3_ready_b1", DataInReady, 1'b1);
        send(8'h12); check("t3_ready_b2", DataInReady, 1'b1);
        send(8'h13); check("t3_ready_b3", DataInReady, 1'b1);
        send(8'h14); check("t3_ready_full", DataInReady, 1'b0);
        DataIn = 8'h15;
        while (cyc < a0 + FrameLen) tick();
        check("t3_ready_before_pop", DataInReady, 1'b0);
        tick();
        check("t3_ready_after_pop", DataInReady, 1'b1);
        send(8'h15);
        DataInValid = 1'b0;
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        wait_frames("t3_frames", 6, 800);
        compare_rx("t3");
        wait_idle("t3_idle", 200);

        // 4: reset in the middle of a frame with bytes queued
        clear_rx();
        send(8'hFF); a0 = last_acc;
        send(8'h33);
        send(8'h44);
        DataInValid = 1'b0;
        while (cyc < a0 + 36) tick();
        Reset = 1'b1;
        tick();
        check("t4_sout",  SOut, 1'b1);
        check("t4_busy",  Busy, 1'b0);
        check("t4_ready", DataInReady, 1'b1);
        Reset = 1'b0;
        any_low = 1'b0;
        for (int t = 0; t < 3 * FrameLen; t++) begin
            tick();
            if (SOut !== 1'b1) any_low = 1'b1;
        end
        check("t4_line_quiet", any_low, 1'b0);
        check("t4_no_frames", rx_q.size(), 0);
        check("t4_busy_after", Busy, 1'b0);

        // 5 + 6: push and pop on one edge at occupancy 2, then push while full
        clear_rx();
        send(8'h51); a0 = last_acc;
        send(8'h52);
        send(8'h53);
        DataInValid = 1'b0;
        while (cyc < a0 + FrameLen) tick();
        DataIn      = 8'h54;
        DataInValid = 1'b1;
        tick();
        check("t5_ready_occ2", DataInReady, 1'b1);
        DataIn = 8'h55;
        tick();
        check("t5_ready_occ3", DataInReady, 1'b1);
        DataIn = 8'h56;
        tick();
        check("t5_ready_occ4", DataInReady, 1'b0);
        DataIn = 8'hEE;
        tick();
        tick();
        check("t6_ready_full", DataInReady, 1'b0);
        DataInValid = 1'b0;
        exp_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56};
        wait_frames("t5_frames", 6, 800);
        compare_rx("t5");
        wait_idle("t5_idle", 200);
        check("t6_no_extra", rx_q.size(), 6);

        // Randomized bytes and gaps
        clear_rx();
        for (int i = 0; i < 10; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            exp_q.push_back(b);
            send(b);
            DataInValid = 1'b0;
            repeat ($urandom_range(0, 120)) tick();
        end
        wait_frames("rnd_frames", 10, 2000);
        compare_rx("rnd");
        wait_idle("rnd_idle", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
